// File: rtl/datapath.sv
// Single-cycle 32-bit MIPS datapath: PC, 32x32 register file, immediate extend, ALU, next-PC and writeback muxes.
// Optional build macro DATAPATH_REGRESET_EN: reset also clears the register file alongside the PC.
module datapath #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [31:0] readdata,
   input  logic        memtoreg,
   input  logic        branch,
   input  logic        jump,
   input  logic        jreg,
   input  logic        jal,
   input  logic [3:0]  alucont,
   input  logic        regdst,
   input  logic        asrcb,
   input  logic        asrca,
   input  logic        rwrite,
   input  logic        extop,
   input  logic [4:0]  reg_s,
   output logic [31:0] pc,
   output logic        zero,
   output logic        neg,
   output logic [31:0] writedata,
   output logic [31:0] writedst,
   output logic [31:0] reg_show
);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_NOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_LUI  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1011;

   logic [31:0] r_pc;
   logic [31:0] r_regs [32];

   logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
   logic [15:0] w_imm;
   logic [31:0] w_imm_sext, w_imm_ext;
   logic [31:0] w_rs_val, w_rt_val;
   logic [31:0] w_alu_a, w_alu_b, w_alu_y;
   logic [31:0] w_pc4, w_pc_next;
   logic [4:0]  w_waddr;
   logic [31:0] w_wdata;
   logic        w_unused;

   assign w_rs     = instr[25:21];
   assign w_rt     = instr[20:16];
   assign w_rd     = instr[15:11];
   assign w_shamt  = instr[10:6];
   assign w_imm    = instr[15:0];
   assign w_unused = &{1'b0, instr[31:26]};

   assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
   assign w_imm_ext  = extop ? w_imm_sext : {16'b0, w_imm};

   // r0 is hardwired to zero on the read side, so its storage never matters
   assign w_rs_val = (w_rs == 5'd0)    ? 32'd0 : r_regs[w_rs];
   assign w_rt_val = (w_rt == 5'd0)    ? 32'd0 : r_regs[w_rt];
   assign reg_show = (reg_s == 5'd0)   ? 32'd0 : r_regs[reg_s];

   assign w_alu_a = asrca ? {27'b0, w_shamt} : w_rs_val;
   assign w_alu_b = asrcb ? w_imm_ext : w_rt_val;

   // NOTE: every combinational output gets a default first so no latch is inferred for unlisted opcodes.
   always_comb begin
      w_alu_y = 32'd0;
      case (alucont)
         ALU_AND:  w_alu_y = w_alu_a & w_alu_b;
         ALU_OR:   w_alu_y = w_alu_a | w_alu_b;
         ALU_ADD:  w_alu_y = w_alu_a + w_alu_b;
         ALU_XOR:  w_alu_y = w_alu_a ^ w_alu_b;
         ALU_NOR:  w_alu_y = ~(w_alu_a | w_alu_b);
         ALU_SLL:  w_alu_y = w_alu_b << w_alu_a[4:0];
         ALU_SUB:  w_alu_y = w_alu_a - w_alu_b;
         ALU_SLT:  w_alu_y = {31'b0, $signed(w_alu_a) < $signed(w_alu_b)};
         ALU_SRL:  w_alu_y = w_alu_b >> w_alu_a[4:0];
         ALU_SRA:  w_alu_y = $unsigned($signed(w_alu_b) >>> w_alu_a[4:0]);
         ALU_LUI:  w_alu_y = w_alu_b << 16;
         ALU_SLTU: w_alu_y = {31'b0, w_alu_a < w_alu_b};
         default:  w_alu_y = 32'd0;
      endcase
   end

   assign zero      = (w_alu_y == 32'd0);
   assign neg       = w_alu_y[31];
   assign writedst  = w_alu_y;
   assign writedata = w_rt_val;

   assign w_pc4 = r_pc + 32'd4;

   // jreg outranks jump, which outranks a taken branch
   always_comb begin
      w_pc_next = w_pc4;
      if (jreg)        w_pc_next = w_rs_val;
      else if (jump)   w_pc_next = {w_pc4[31:28], instr[25:0], 2'b00};
      else if (branch) w_pc_next = w_pc4 + {w_imm_sext[29:0], 2'b00};
   end

   assign w_waddr = jal ? 5'd31 : (regdst ? w_rd : w_rt);
   assign w_wdata = jal ? w_pc4 : (memtoreg ? readdata : w_alu_y);

   // NOTE: state registers use non-blocking assignments so every read this cycle sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (reset) r_pc <= PC_RESET;
      else       r_pc <= w_pc_next;
   end

`ifdef DATAPATH_REGRESET_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      end else if (rwrite && (w_waddr != 5'd0)) begin
         r_regs[w_waddr] <= w_wdata;
      end
   end
`else
   // NOTE: the register file has no reset so it can map onto plain RAM; contents start undefined.
   always_ff @(posedge clk) begin
      if (rwrite && (w_waddr != 5'd0)) r_regs[w_waddr] <= w_wdata;
   end
`endif

   assign pc = r_pc;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath: PC sequencing, branches/jumps, writeback paths and ALU ops.
module tb_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr, readdata;
   logic        memtoreg, branch, jump, jreg, jal;
   logic [3:0]  alucont;
   logic        regdst, asrcb, asrca, rwrite, extop;
   logic [4:0]  reg_s;
   logic [31:0] pc, writedata, writedst, reg_show;
   logic        zero, neg;

   int n_checks = 0;
   int n_fail   = 0;

   datapath #(.PC_RESET(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .instr(instr), .readdata(readdata),
      .memtoreg(memtoreg), .branch(branch), .jump(jump), .jreg(jreg), .jal(jal),
      .alucont(alucont), .regdst(regdst), .asrcb(asrcb), .asrca(asrca),
      .rwrite(rwrite), .extop(extop), .reg_s(reg_s), .pc(pc), .zero(zero),
      .neg(neg), .writedata(writedata), .writedst(writedst), .reg_show(reg_show)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] itype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
      return {6'b0, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh);
      return {6'b0, rs, rt, rd, sh, 6'b0};
   endfunction

   task automatic idle();
      instr = 32'd0; readdata = 32'd0; memtoreg = 0; branch = 0; jump = 0;
      jreg = 0; jal = 0; alucont = 4'd0; regdst = 0; asrcb = 0; asrca = 0;
      rwrite = 0; extop = 0; reg_s = 5'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic show(input string tag, input logic [4:0] r, input logic [31:0] exp);
      reg_s = r;
      #1;
      check(tag, reg_show, exp);
   endtask

   // Load a register via addi/ori-style immediate write: rt = ext(imm)
   task automatic load_imm(input logic [4:0] rt, input logic [15:0] imm, input logic sext);
      idle();
      instr = itype(5'd0, rt, imm); asrcb = 1; extop = sext; alucont = 4'b0010; rwrite = 1;
      tick();
   endtask

   // Combinational ALU vector, no writeback
   task automatic alu_vec(input string tag, input logic [3:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] sh, input logic aa,
                          input logic ab, input logic ex, input logic [15:0] imm,
                          input logic [31:0] exp);
      idle();
      alucont = op; asrca = aa; asrcb = ab; extop = ex;
      instr = ab ? itype(rs, rt, imm) : rtype(rs, rt, 5'd0, sh);
      #1;
      check(tag, writedst, exp);
      check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 32'd0});
      tick();
   endtask

   initial begin
      idle();
      reset = 1;
      #1;
      tick();
      check("reset_pc", pc, 32'h0);
      reset = 0;

      tick();
      check("nop_pc4", pc, 32'h4);
      tick();
      check("nop_pc8", pc, 32'h8);

      // beq back to itself: 8 + 4 + (-1<<2) = 8
      idle();
      instr = itype(5'd0, 5'd0, 16'hFFFF); branch = 1;
      tick();
      check("beq_taken_pc", pc, 32'h8);

      // addi r1,r0,-5 with branch not taken
      idle();
      instr = itype(5'd0, 5'd1, 16'hFFFB); asrcb = 1; extop = 1; alucont = 4'b0010; rwrite = 1;
      #1;
      check("addi_alu", writedst, 32'hFFFF_FFFB);
      check("addi_neg", {31'b0, neg}, 32'd1);
      check("addi_zero", {31'b0, zero}, 32'd0);
      tick();
      check("branch_nt_pc", pc, 32'hC);
      show("addi_r1", 5'd1, 32'hFFFF_FFFB);

      // addi r1,r0,1: old value visible until the edge
      idle();
      instr = itype(5'd0, 5'd1, 16'h0001); asrcb = 1; extop = 1; alucont = 4'b0010; rwrite = 1;
      reg_s = 5'd1;
      #1;
      check("rdw_old", reg_show, 32'hFFFF_FFFB);
      tick();
      check("rdw_new", reg_show, 32'h1);
      check("pc_10", pc, 32'h10);

      // jal target 0x40 at pc 0x10
      idle();
      instr = {6'b0, 26'h40}; jump = 1; jal = 1; rwrite = 1;
      tick();
      check("jal_pc", pc, 32'h100);
      show("jal_r31", 5'd31, 32'h14);

      // jalr r31 with jump also asserted: jreg wins, link uses pc4, target uses old r31
      idle();
      instr = itype(5'd31, 5'd0, 16'h0000); jreg = 1; jump = 1; jal = 1; rwrite = 1;
      tick();
      check("jreg_pc", pc, 32'h14);
      show("jalr_r31", 5'd31, 32'h104);

      // sll r2,r1,4
      idle();
      instr = rtype(5'd0, 5'd1, 5'd2, 5'd4); asrca = 1; regdst = 1; alucont = 4'b0101; rwrite = 1;
      tick();
      show("sll_r2", 5'd2, 32'h10);

      // write to r0 is ignored
      idle();
      instr = itype(5'd0, 5'd0, 16'h0005); asrcb = 1; extop = 1; alucont = 4'b0010; rwrite = 1;
      #1;
      check("r0_alu", writedst, 32'h5);
      tick();
      show("r0_stays", 5'd0, 32'h0);

      load_imm(5'd3, 16'h0020, 1'b1);
      load_imm(5'd4, 16'h00AB, 1'b0);
      load_imm(5'd7, 16'hFFFB, 1'b1);
      show("r7_load", 5'd7, 32'hFFFF_FFFB);

      // sw r4, 8(r3)
      idle();
      instr = itype(5'd3, 5'd4, 16'h0008); asrcb = 1; extop = 1; alucont = 4'b0010;
      #1;
      check("sw_addr", writedst, 32'h28);
      check("sw_data", writedata, 32'hAB);
      tick();

      // lw r5, 0(r3)
      idle();
      instr = itype(5'd3, 5'd5, 16'h0000); asrcb = 1; extop = 1; alucont = 4'b0010;
      memtoreg = 1; rwrite = 1; readdata = 32'h1234;
      tick();
      show("lw_r5", 5'd5, 32'h1234);

      //       tag          op       rs     rt     sh     aa ab ex imm       expected
      alu_vec("sub",       4'b0110, 5'd4,  5'd3,  5'd0,  0, 0, 0, 16'h0,    32'h0000_008B);
      alu_vec("sub_self",  4'b0110, 5'd3,  5'd3,  5'd0,  0, 0, 0, 16'h0,    32'h0);
      alu_vec("and",       4'b0000, 5'd3,  5'd4,  5'd0,  0, 0, 0, 16'h0,    32'h20);
      alu_vec("or",        4'b0001, 5'd3,  5'd4,  5'd0,  0, 0, 0, 16'h0,    32'hAB);
      alu_vec("xor",       4'b0011, 5'd3,  5'd4,  5'd0,  0, 0, 0, 16'h0,    32'h8B);
      alu_vec("nor",       4'b0100, 5'd0,  5'd0,  5'd0,  0, 0, 0, 16'h0,    32'hFFFF_FFFF);
      alu_vec("srl",       4'b1000, 5'd0,  5'd7,  5'd28, 1, 0, 0, 16'h0,    32'hF);
      alu_vec("sra",       4'b1001, 5'd0,  5'd7,  5'd1,  1, 0, 0, 16'h0,    32'hFFFF_FFFD);
      alu_vec("slt",       4'b0111, 5'd7,  5'd1,  5'd0,  0, 0, 0, 16'h0,    32'h1);
      alu_vec("sltu",      4'b1011, 5'd7,  5'd1,  5'd0,  0, 0, 0, 16'h0,    32'h0);
      alu_vec("lui",       4'b1010, 5'd0,  5'd0,  5'd0,  0, 1, 0, 16'h1234, 32'h1234_0000);
      alu_vec("add_wrap",  4'b0010, 5'd7,  5'd7,  5'd0,  0, 0, 0, 16'h0,    32'hFFFF_FFF6);
      alu_vec("zext",      4'b0010, 5'd0,  5'd0,  5'd0,  0, 1, 0, 16'hFFFF, 32'h0000_FFFF);
      alu_vec("sext",      4'b0010, 5'd0,  5'd0,  5'd0,  0, 1, 1, 16'hFFFF, 32'hFFFF_FFFF);
      alu_vec("undef_op",  4'b1100, 5'd3,  5'd4,  5'd0,  0, 0, 0, 16'h0,    32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
